// File: rtl/surf_id_reader.sv
// rtl/surf_id_reader.sv - Wishbone initiator that fetches DEVICE, VERSION and DNA from the SURF ID target
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   start_i                  pulse: launch a read sequence (ignored while busy_o)
//   wb_cyc_o .. wb_sel_o     initiator side of the wishbone segment
//   wb_dat_i, wb_ack_i,      target responses; wb_rty_i is handled like wb_err_i
//   wb_err_i, wb_rty_i
//   device_o, version_o,     ID values, latched only when a sequence completes cleanly
//   dna_o, ctrlstat_o
//   busy_o                   sequence in progress
//   done_o, err_o            sticky outcome of the last sequence, cleared by the next start
//
// Build option: define SURF_ID_READER_CTRLSTAT_EN to add a ctrlstat read (offset 0x00C)
// before DONE; without it ctrlstat_o is tied to 0.

module surf_id_reader #(
  parameter int                     WB_ADR_BITS = 11,
  parameter logic [WB_ADR_BITS-1:0] BASE_ADDR   = '0,
  parameter int                     DNA_BITS    = 96,
  parameter int                     TIMEOUT     = 255,
  parameter bit                     AUTO_START  = 1'b1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start_i,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [WB_ADR_BITS-1:0] wb_adr_o,
  output logic [31:0]            wb_dat_o,
  output logic [3:0]             wb_sel_o,
  input  logic [31:0]            wb_dat_i,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  input  logic                   wb_rty_i,
  output logic [31:0]            device_o,
  output logic [31:0]            version_o,
  output logic [DNA_BITS-1:0]    dna_o,
  output logic [31:0]            ctrlstat_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam logic [6:0]  DNA_LAST  = 7'(DNA_BITS - 1);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_DEV,
    S_RD_VER,
    S_WR_DNA,
    S_RD_DNA,
`ifdef SURF_ID_READER_CTRLSTAT_EN
    S_RD_CTRL,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic                gap_q, gap_d;     // bus state is idling its one-cycle gap before the strobe
  logic                first_q;          // first cycle after reset release, for AUTO_START
  logic [15:0]         tmo_q;
  logic [6:0]          cnt_q;
  logic [DNA_BITS-1:0] shreg_q, shreg_nx;
  logic [31:0]         dev_q, ver_q, dev_nx, ver_nx;
  logic                in_bus, bus_act, abort_rsp, ack_ok, launch;

  always_comb begin
    in_bus = 1'b0;
    case (state_q)
      S_RD_DEV, S_RD_VER, S_WR_DNA, S_RD_DNA: in_bus = 1'b1;
`ifdef SURF_ID_READER_CTRLSTAT_EN
      S_RD_CTRL: in_bus = 1'b1;
`endif
      default: in_bus = 1'b0;
    endcase
  end

  assign bus_act   = in_bus && !gap_q;
  // err/rty beat a coincident ack
  assign abort_rsp = bus_act && (wb_err_i || wb_rty_i);
  assign ack_ok    = bus_act && wb_ack_i && !(wb_err_i || wb_rty_i);
  assign launch    = (state_q == S_IDLE) && (start_i || (AUTO_START && first_q));
  assign busy_o    = (state_q != S_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      first_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch) state_d = S_RD_DEV;
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      S_RD_DEV, S_RD_VER, S_WR_DNA, S_RD_DNA
`ifdef SURF_ID_READER_CTRLSTAT_EN
      , S_RD_CTRL
`endif
      : begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (abort_rsp) begin
          state_d = S_ERR;
        end else if (ack_ok) begin
          // the target's ack toggles, so every follow-on strobe needs a quiet cycle first
          gap_d = 1'b1;
          case (state_q)
            S_RD_DEV: state_d = S_RD_VER;
            S_RD_VER: state_d = S_WR_DNA;
            S_WR_DNA: state_d = S_RD_DNA;
            S_RD_DNA: begin
              if (cnt_q == DNA_LAST) begin
`ifdef SURF_ID_READER_CTRLSTAT_EN
                state_d = S_RD_CTRL;
`else
                state_d = S_DONE;
                gap_d   = 1'b0;
`endif
              end
            end
`ifdef SURF_ID_READER_CTRLSTAT_EN
            S_RD_CTRL: begin
              state_d = S_DONE;
              gap_d   = 1'b0;
            end
`endif
            default: state_d = S_IDLE;
          endcase
        end else if (tmo_q == TMO_LIMIT) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the shadow registers, so the DONE-entry latch sees the final read
  assign shreg_nx = (ack_ok && state_q == S_RD_DNA) ? {wb_dat_i[0], shreg_q[DNA_BITS-1:1]} : shreg_q;
  assign dev_nx   = (ack_ok && state_q == S_RD_DEV) ? wb_dat_i : dev_q;
  assign ver_nx   = (ack_ok && state_q == S_RD_VER) ? wb_dat_i : ver_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_q     <= '0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      dev_q     <= '0;
      ver_q     <= '0;
      device_o  <= '0;
      version_o <= '0;
      dna_o     <= '0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      // counts cycles of an outstanding strobe; zero on the first strobe cycle
      tmo_q   <= (bus_act && !wb_ack_i && !abort_rsp) ? tmo_q + 16'd1 : 16'd0;
      shreg_q <= shreg_nx;
      dev_q   <= dev_nx;
      ver_q   <= ver_nx;
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
      end else if (ack_ok && state_q == S_RD_DNA) begin
        cnt_q <= cnt_q + 7'd1;
      end
      if (launch) begin
        done_o <= 1'b0;
        err_o  <= 1'b0;
      end
      if (state_d == S_DONE) begin
        device_o  <= dev_nx;
        version_o <= ver_nx;
        dna_o     <= shreg_nx;
        done_o    <= 1'b1;
        err_o     <= 1'b0;
      end
      if (state_d == S_ERR) begin
        done_o <= 1'b0;
        err_o  <= 1'b1;
      end
    end
  end

`ifdef SURF_ID_READER_CTRLSTAT_EN
  // RD_CTRL is the only way into DONE, so its ack data is the word to keep
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrlstat_o <= '0;
    end else if (state_d == S_DONE) begin
      ctrlstat_o <= wb_dat_i;
    end
  end
`else
  assign ctrlstat_o = 32'd0;
`endif

  always_comb begin
    wb_cyc_o = bus_act;
    wb_stb_o = bus_act;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    if (bus_act) begin
      wb_sel_o = 4'hF;
      case (state_q)
        S_RD_DEV: wb_adr_o = BASE_ADDR;
        S_RD_VER: wb_adr_o = BASE_ADDR + WB_ADR_BITS'(4);
        S_WR_DNA: begin
          // bit 31 of the DNA word reloads the target's DNA shifter
          wb_adr_o = BASE_ADDR + WB_ADR_BITS'(8);
          wb_we_o  = 1'b1;
          wb_dat_o = 32'h8000_0000;
          wb_sel_o = 4'b1000;
        end
        S_RD_DNA: wb_adr_o = BASE_ADDR + WB_ADR_BITS'(8);
`ifdef SURF_ID_READER_CTRLSTAT_EN
        S_RD_CTRL: wb_adr_o = BASE_ADDR + WB_ADR_BITS'(12);
`endif
        default: wb_adr_o = '0;
      endcase
    end
  end

endmodule
